fila_decodifica_instrucao: RTL and testbench

Parametrised successor to the combinational MIPS field splitter. It holds fetched 32-bit instructions in a DEPTH-entry FIFO with valid/ready handshakes on both sides, and decodes the head entry. Decoded outputs are the R/I/J fields, an extended immediate, the jump target and a format class. It sits between instruction fetch and the register-file/control stage and decouples fetch stalls from decode stalls.

---
 rtl/fila_decodifica_instrucao_if.sv | 46 ++++
 rtl/fila_decodifica_instrucao.sv | 128 ++++++++++++
 tb/tb_fila_decodifica_instrucao.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fila_decodifica_instrucao_if.sv
// Handshake and decoded-field bundle between fetch, the decode FIFO and its consumer.
// With ILEGAL_DETECT_EN defined the bundle also carries the Ilegal flag.
interface fila_decodifica_instrucao_if #(
  parameter int DEPTH     = 4,
  parameter int IMM_WIDTH = 32
) ();
  localparam int OW = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          instrucao;
  logic                 out_valid;
  logic                 out_ready;
  logic [5:0]           Op_code;
  logic [4:0]           Register_rs;
  logic [4:0]           Register_rt;
  logic [4:0]           Register_rd;
  logic [4:0]           Shamt;
  logic [5:0]           Funct;
  logic [15:0]          Endereco;
  logic [IMM_WIDTH-1:0] Imediato_ext;
  logic [25:0]          Alvo_salto;
  logic [1:0]           Tipo;
  logic [OW-1:0]        ocupacao;
`ifdef ILEGAL_DETECT_EN
  logic                 Ilegal;
`endif

  modport slave (
    input  in_valid, instrucao, out_ready,
    output in_ready, out_valid, Op_code, Register_rs, Register_rt, Register_rd,
           Shamt, Funct, Endereco, Imediato_ext, Alvo_salto, Tipo, ocupacao
`ifdef ILEGAL_DETECT_EN
    , output Ilegal
`endif
  );

  modport master (
    output in_valid, instrucao, out_ready,
    input  in_ready, out_valid, Op_code, Register_rs, Register_rt, Register_rd,
           Shamt, Funct, Endereco, Imediato_ext, Alvo_salto, Tipo, ocupacao
`ifdef ILEGAL_DETECT_EN
    , input Ilegal
`endif
  );
endinterface

// File: rtl/fila_decodifica_instrucao.sv
// DEPTH-entry instruction FIFO that decodes its head entry into MIPS R/I/J fields.
// Optional: define ILEGAL_DETECT_EN to flag unsupported opcodes/functs (Tipo forced to 11).
module fila_decodifica_instrucao #(
  parameter int DEPTH     = 4,
  parameter int IMM_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  fila_decodifica_instrucao_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          push, pop, full, empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && bus.out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.instrucao;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.ocupacao  = count;

  logic [31:0]          head;
  logic [5:0]           op;
  logic                 zext;
  logic                 sign_bit;
  logic [IMM_WIDTH-1:0] imm_ext;
  logic [1:0]           tipo_raw;

  assign head     = mem[rd_ptr];
  assign op       = head[31:26];
  assign zext     = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
  assign sign_bit = head[15] & ~zext;

  generate
    if (IMM_WIDTH == 16) begin : g_imm16
      assign imm_ext = head[15:0];
    end else begin : g_immw
      assign imm_ext = {{(IMM_WIDTH-16){sign_bit}}, head[15:0]};
    end
  endgenerate

`ifdef ILEGAL_DETECT_EN
  logic ilegal_raw;

  always_comb begin
    ilegal_raw = 1'b0;
    case (op)
      6'h00: begin
        case (head[5:0])
          6'h00, 6'h02, 6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: ilegal_raw = 1'b0;
          default: ilegal_raw = 1'b1;
        endcase
      end
      6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
      6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: ilegal_raw = 1'b0;
      default: ilegal_raw = 1'b1;
    endcase
  end
`endif

  always_comb begin
    tipo_raw = 2'b01;
    if (op == 6'h00)                      tipo_raw = 2'b00;
    else if (op == 6'h02 || op == 6'h03)  tipo_raw = 2'b10;
`ifdef ILEGAL_DETECT_EN
    if (ilegal_raw) tipo_raw = 2'b11;
`endif
  end

  // Fields are gated with out_valid so an empty FIFO never shows stale storage.
  always_comb begin
    bus.Op_code      = '0;
    bus.Register_rs  = '0;
    bus.Register_rt  = '0;
    bus.Register_rd  = '0;
    bus.Shamt        = '0;
    bus.Funct        = '0;
    bus.Endereco     = '0;
    bus.Imediato_ext = '0;
    bus.Alvo_salto   = '0;
    bus.Tipo         = '0;
`ifdef ILEGAL_DETECT_EN
    bus.Ilegal       = 1'b0;
`endif
    if (!empty) begin
      bus.Op_code      = op;
      bus.Register_rs  = head[25:21];
      bus.Register_rt  = head[20:16];
      bus.Register_rd  = head[15:11];
      bus.Shamt        = head[10:6];
      bus.Funct        = head[5:0];
      bus.Endereco     = head[15:0];
      bus.Imediato_ext = imm_ext;
      bus.Alvo_salto   = head[25:0];
      bus.Tipo         = tipo_raw;
`ifdef ILEGAL_DETECT_EN
      bus.Ilegal       = ilegal_raw;
`endif
    end
  end
endmodule

// File: tb/tb_fila_decodifica_instrucao.sv
// Directed bench for fila_decodifica_instrucao (DEPTH=4, IMM_WIDTH=32).
// Ilegal checks compile in when ILEGAL_DETECT_EN is defined.
module tb_fila_decodifica_instrucao;
  logic clock = 1'b0;
  logic reset;
  logic flush;
  int   n_vec = 0;
  int   n_err = 0;

  fila_decodifica_instrucao_if #(.DEPTH(4), .IMM_WIDTH(32)) bus ();

  fila_decodifica_instrucao #(.DEPTH(4), .IMM_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] head_word();
    return {bus.Op_code, bus.Alvo_salto};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    bus.in_valid  = 1'b1;
    bus.instrucao = w;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic pop_word();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  logic [31:0] w [5];

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.instrucao = '0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_ocupacao",  32'(bus.ocupacao),  32'd0);
    chk("rst_imm",       bus.Imediato_ext,   32'd0);
    chk("rst_tipo",      32'(bus.Tipo),      32'd0);
    tick();
    reset = 1'b0;
    tick();

    // add $t0,$t1,$t2
    push_word(32'h012A4020);
    chk("add_valid", 32'(bus.out_valid),   32'd1);
    chk("add_tipo",  32'(bus.Tipo),        32'd0);
    chk("add_rs",    32'(bus.Register_rs), 32'd9);
    chk("add_rt",    32'(bus.Register_rt), 32'd10);
    chk("add_rd",    32'(bus.Register_rd), 32'd8);
    chk("add_funct", 32'(bus.Funct),       32'h20);
    chk("add_occ",   32'(bus.ocupacao),    32'd1);
    pop_word();
    chk("empty_valid", 32'(bus.out_valid), 32'd0);
    chk("empty_funct", 32'(bus.Funct),     32'd0);

    push_word(32'h2128FFFF);
    push_word(32'h3128FFFF);
    push_word(32'h08000010);
    push_word(32'h24020005);
    chk("i_occ",       32'(bus.ocupacao),  32'd4);
    chk("addi_imm",    bus.Imediato_ext,   32'hFFFFFFFF);
    chk("addi_tipo",   32'(bus.Tipo),      32'd1);
    chk("addi_end",    32'(bus.Endereco),  32'hFFFF);
    chk("addi_op",     32'(bus.Op_code),   32'h08);
    pop_word();
    chk("andi_imm",    bus.Imediato_ext,   32'h0000FFFF);
    pop_word();
    chk("j_tipo",      32'(bus.Tipo),      32'd2);
    chk("j_alvo",      32'(bus.Alvo_salto), 32'h10);
    pop_word();
    chk("addiu_imm",   bus.Imediato_ext,   32'd5);
    pop_word();
    chk("drain_empty", 32'(bus.out_valid), 32'd0);

    // overfill with consumer stalled
    w[0] = 32'h8D280004; w[1] = 32'h012A4022; w[2] = 32'hAD280008;
    w[3] = 32'h0C000123; w[4] = 32'h112AFFFE;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid  = 1'b1;
      bus.instrucao = w[i];
      tick();
      if (i == 3) chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    end
    chk("full_occ",  32'(bus.ocupacao), 32'd4);
    chk("full_head", head_word(),       w[0]);
    // stalled head must hold
    tick();
    chk("hold_head", head_word(),       w[0]);
    // full with push and pop together: pop only
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("fullpop_occ",   32'(bus.ocupacao), 32'd3);
    chk("fullpop_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("drain_%0d", i), head_word(), w[i]);
      pop_word();
    end
    chk("drain_done", 32'(bus.ocupacao), 32'd0);

    // flush with a concurrent push
    push_word(32'h11111111);
    push_word(32'h22222222);
    push_word(32'h33333333);
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instrucao = 32'hAAAAAAAA;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_occ",   32'(bus.ocupacao),  32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    push_word(32'h012A4020);
    chk("postflush_head", head_word(),       32'h012A4020);
    chk("postflush_occ",  32'(bus.ocupacao), 32'd1);

`ifdef ILEGAL_DETECT_EN
    chk("add_ilegal", 32'(bus.Ilegal), 32'd0);
    pop_word();
    push_word(32'hFC000000);
    chk("op3f_ilegal", 32'(bus.Ilegal), 32'd1);
    chk("op3f_tipo",   32'(bus.Tipo),   32'd3);
    pop_word();
    push_word(32'h0000003F);
    chk("f3f_ilegal",  32'(bus.Ilegal), 32'd1);
    chk("f3f_tipo",    32'(bus.Tipo),   32'd3);
    pop_word();
`else
    pop_word();
    push_word(32'hFC000000);
    chk("op3f_tipo",   32'(bus.Tipo),   32'd1);
    pop_word();
    push_word(32'h0000003F);
    chk("f3f_tipo",    32'(bus.Tipo),   32'd0);
    pop_word();
`endif

    // asynchronous reset mid-stream
    push_word(32'h2128FFFF);
    push_word(32'h3128FFFF);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_occ",   32'(bus.ocupacao),  32'd0);
    chk("arst_ready", 32'(bus.in_ready),  32'd1);
    chk("arst_imm",   bus.Imediato_ext,   32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
